pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Game sequencer for the camera ball-catch display; runs in the pixel clock domain.
- Drives ball_x, ball_y, score, game_over and is_idle into the overlay/display block.
- Counts per-pixel hit qualifiers (ball area AND camera motion) over each frame, scores catches and detects misses.
- Manages lives, serve delay, ball speed ramp and game-over timeout.

Parameters:
- SCREEN_H, 480, visible lines.
- BALL_SIZE, 20, ball sprite edge in pixels.
- HIT_THRESH, 16, hit pixels per frame needed to register a catch.
- INIT_LIVES, 3, lives at game start (1..7).
- BASE_SPEED, 2, initial fall speed in lines per frame.
- MAX_SPEED, 8, speed ceiling.
- SPAWN_DELAY, 30, frames spent in SERVE before the ball appears.
- OVER_FRAMES, 180, frames held in OVER before auto-return to IDLE.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-clk pulse at the start of each frame (vsync edge).
- start_btn  in  1  one-clk debounced start pulse.
- hit_pixel  in  1  per-pixel qualifier: hit area AND motion detected.
- ball_x  out  10  ball left edge.
- ball_y  out  10  ball top edge.
- score  out  8  catches, binary, 0..99.
- lives  out  3  remaining lives.
- speed  out  4  current fall speed.
- game_over  out  1  high in OVER.
- is_idle  out  1  high in every state except PLAY.
- hit_pulse  out  1  one clk on a catch.
- miss_pulse  out  1  one clk on a miss.

Behaviour:
Reset values (all async on reset_n low):
- state=IDLE, ball_x=310, ball_y=0, score=0, lives=INIT_LIVES, speed=BASE_SPEED.
- game_over=0, is_idle=1, pulses=0, hit_cnt=0, frame_cnt=0, ramp_cnt=0, lfsr=9'h1FF.

Free-running logic:
- 9-bit LFSR, x^9+x^5+1, advances every clk and never reaches 0.

Hit counter (8-bit, saturates at 255):
- Increments on hit_pixel only in PLAY.
- On frame_start it is sampled first, then cleared.
- Cleared on every state change.

State machine (all timed transitions evaluate only on frame_start unless stated):
- IDLE: start_btn -> SERVE (same clk). score=0, lives=INIT_LIVES, speed=BASE_SPEED, ramp_cnt=0, frame_cnt=0.
- SERVE: frame_cnt increments per frame_start. When frame_cnt reaches SPAWN_DELAY-1 on a frame_start:
  - ball_x={1'b0,lfsr} (range 1..511, always within 640-BALL_SIZE);
  - ball_y=0, frame_cnt=0;
  - go to PLAY.
- PLAY, on frame_start, first match wins:
  1. hit_cnt>=HIT_THRESH (catch):
     - score+1, saturating at 99; hit_pulse for one clk; -> SERVE.
     - ramp_cnt+1; when it reaches 5: ramp_cnt=0 and speed=min(speed+1, MAX_SPEED).
  2. ball_y+speed > SCREEN_H-BALL_SIZE (miss, computed 11-bit, no wrap):
     - miss_pulse for one clk; lives-1.
     - lives was 1 -> OVER, else -> SERVE.
  3. Otherwise ball_y += speed.
  - A catch and a bottom crossing in the same frame count as a catch.
- OVER:
  - game_over=1; ball_x and ball_y frozen.
  - start_btn -> SERVE with the full IDLE-start initialisation.
  - Otherwise after OVER_FRAMES frame_starts -> IDLE.

Output rules:
- start_btn is ignored in SERVE and PLAY.
- is_idle and game_over are registered from state and change on the clk after the transition.
- ball_x and ball_y change only on frame_start clks, so they never tear mid-frame.
- score stays valid in OVER and IDLE, and is cleared only at start.
- reset_n low mid-operation returns everything to the reset values immediately, with no pending pulses.

Test Plan:
1. Reset, then start_btn, then 30 frame_starts -> PLAY. ball_x = LFSR value, ball_y=0, is_idle=0 on the next clk.
2. In PLAY (speed 2), hold hit_pixel for 16 clks in one frame, then frame_start -> hit_pulse, score 0->1, state SERVE. Repeat 5 catches -> speed=3.
3. No hits from ball_y=0 at speed 2 -> ball_y steps 0,2,...,460. The next frame_start (462>460) -> miss_pulse, lives 3->2, SERVE. Three such misses -> game_over=1, lives=0.
4. 15 hit pixels then frame_start at ball_y=460 -> miss (below threshold). 16 hit pixels at ball_y=460 -> catch wins, lives unchanged.
5. In OVER, 180 frame_starts -> IDLE, score retained. In a separate run, start_btn at OVER frame 10 -> SERVE with score=0, lives=3, speed=2.
6. reset_n low for 1 clk while in PLAY with score=42 -> all outputs return to reset values asynchronously. Score saturation: preload 99 catches, one more catch -> score stays 99 and hit_pulse still asserts.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// pong_game_ctrl
//   Game sequencer for the camera ball-catch display (pixel clock domain).
//   A ball falls from the top of the screen; the player "catches" it by moving
//   in front of the camera over the ball area.  Per-pixel hit qualifiers are
//   counted over a frame and judged at the next frame_start.
//
// Ports
//   clk          pixel clock
//   reset_n      asynchronous active-low reset
//   frame_start  one-clk pulse at the start of each frame
//   start_btn    one-clk debounced start pulse (honoured in IDLE and OVER)
//   hit_pixel    per-pixel qualifier: ball area AND camera motion
//   ball_x       ball left edge (updated on frame_start clks only)
//   ball_y       ball top edge (updated on frame_start clks only)
//   score        catches, binary, saturating at 99
//   lives        remaining lives
//   speed        current fall speed in lines per frame
//   game_over    high while in OVER (registered from state)
//   is_idle      high in every state except PLAY (registered from state)
//   hit_pulse    one clk on a catch
//   miss_pulse   one clk on a miss
// -----------------------------------------------------------------------------
module pong_game_ctrl #(
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 20,
    parameter int HIT_THRESH  = 16,
    parameter int INIT_LIVES  = 3,
    parameter int BASE_SPEED  = 2,
    parameter int MAX_SPEED   = 8,
    parameter int SPAWN_DELAY = 30,
    parameter int OVER_FRAMES = 180
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       start_btn,
    input  logic       hit_pixel,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [7:0] score,
    output logic [2:0] lives,
    output logic [3:0] speed,
    output logic       game_over,
    output logic       is_idle,
    output logic       hit_pulse,
    output logic       miss_pulse
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    localparam logic [7:0]  SPAWN_LAST = 8'(SPAWN_DELAY - 1);
    localparam logic [7:0]  OVER_LAST  = 8'(OVER_FRAMES - 1);
    localparam logic [7:0]  HIT_LIM    = 8'(HIT_THRESH);
    localparam logic [10:0] Y_LIMIT    = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [2:0]  LIVES_INIT = 3'(INIT_LIVES);
    localparam logic [3:0]  SPEED_INIT = 4'(BASE_SPEED);
    localparam logic [3:0]  SPEED_MAX  = 4'(MAX_SPEED);

    logic [1:0] state_reg,      state_next;
    logic [9:0] ball_x_reg,     ball_x_next;
    logic [9:0] ball_y_reg,     ball_y_next;
    logic [7:0] score_reg,      score_next;
    logic [2:0] lives_reg,      lives_next;
    logic [3:0] speed_reg,      speed_next;
    logic [2:0] ramp_cnt_reg,   ramp_cnt_next;
    logic [7:0] frame_cnt_reg,  frame_cnt_next;
    logic [7:0] hit_cnt_reg,    hit_cnt_next;
    logic [8:0] lfsr_reg;
    logic       hit_pulse_reg,  hit_pulse_next;
    logic       miss_pulse_reg, miss_pulse_next;
    logic       game_over_reg;
    logic       is_idle_reg;

    // Bottom-crossing test done one bit wider so ball_y+speed cannot wrap.
    logic [10:0] y_sum;
    assign y_sum = {1'b0, ball_y_reg} + {7'd0, speed_reg};

    always_comb begin
        state_next      = state_reg;
        ball_x_next     = ball_x_reg;
        ball_y_next     = ball_y_reg;
        score_next      = score_reg;
        lives_next      = lives_reg;
        speed_next      = speed_reg;
        ramp_cnt_next   = ramp_cnt_reg;
        frame_cnt_next  = frame_cnt_reg;
        hit_cnt_next    = hit_cnt_reg;
        hit_pulse_next  = 1'b0;
        miss_pulse_next = 1'b0;

        // Hit counter: the value judged at frame_start is the registered one,
        // so clearing here on frame_start is "sample first, then clear".
        if (frame_start) begin
            hit_cnt_next = 8'd0;
        end else if (state_reg == ST_PLAY && hit_pixel && hit_cnt_reg != 8'hFF) begin
            hit_cnt_next = hit_cnt_reg + 8'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start_btn) begin
                    state_next     = ST_SERVE;
                    score_next     = 8'd0;
                    lives_next     = LIVES_INIT;
                    speed_next     = SPEED_INIT;
                    ramp_cnt_next  = 3'd0;
                    frame_cnt_next = 8'd0;
                end
            end
            ST_SERVE: begin
                if (frame_start) begin
                    if (frame_cnt_reg == SPAWN_LAST) begin
                        state_next     = ST_PLAY;
                        // LFSR is never 0, so x lands in 1..511.
                        ball_x_next    = {1'b0, lfsr_reg};
                        ball_y_next    = 10'd0;
                        frame_cnt_next = 8'd0;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (frame_start) begin
                    if (hit_cnt_reg >= HIT_LIM) begin
                        // A catch beats a simultaneous bottom crossing.
                        state_next     = ST_SERVE;
                        hit_pulse_next = 1'b1;
                        frame_cnt_next = 8'd0;
                        if (score_reg < 8'd99) begin
                            score_next = score_reg + 8'd1;
                        end
                        if (ramp_cnt_reg == 3'd4) begin
                            ramp_cnt_next = 3'd0;
                            speed_next    = (speed_reg >= SPEED_MAX) ? SPEED_MAX
                                                                     : speed_reg + 4'd1;
                        end else begin
                            ramp_cnt_next = ramp_cnt_reg + 3'd1;
                        end
                    end else if (y_sum > Y_LIMIT) begin
                        miss_pulse_next = 1'b1;
                        lives_next      = lives_reg - 3'd1;
                        frame_cnt_next  = 8'd0;
                        state_next      = (lives_reg == 3'd1) ? ST_OVER : ST_SERVE;
                    end else begin
                        ball_y_next = y_sum[9:0];
                    end
                end
            end
            default: begin // ST_OVER
                if (start_btn) begin
                    state_next     = ST_SERVE;
                    score_next     = 8'd0;
                    lives_next     = LIVES_INIT;
                    speed_next     = SPEED_INIT;
                    ramp_cnt_next  = 3'd0;
                    frame_cnt_next = 8'd0;
                end else if (frame_start) begin
                    if (frame_cnt_reg == OVER_LAST) begin
                        state_next     = ST_IDLE;
                        frame_cnt_next = 8'd0;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 8'd1;
                    end
                end
            end
        endcase

        // Each state starts with a fresh hit count.
        if (state_next != state_reg) begin
            hit_cnt_next = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            ball_x_reg     <= 10'd310;
            ball_y_reg     <= 10'd0;
            score_reg      <= 8'd0;
            lives_reg      <= LIVES_INIT;
            speed_reg      <= SPEED_INIT;
            ramp_cnt_reg   <= 3'd0;
            frame_cnt_reg  <= 8'd0;
            hit_cnt_reg    <= 8'd0;
            lfsr_reg       <= 9'h1FF;
            hit_pulse_reg  <= 1'b0;
            miss_pulse_reg <= 1'b0;
            game_over_reg  <= 1'b0;
            is_idle_reg    <= 1'b1;
        end else begin
            state_reg      <= state_next;
            ball_x_reg     <= ball_x_next;
            ball_y_reg     <= ball_y_next;
            score_reg      <= score_next;
            lives_reg      <= lives_next;
            speed_reg      <= speed_next;
            ramp_cnt_reg   <= ramp_cnt_next;
            frame_cnt_reg  <= frame_cnt_next;
            hit_cnt_reg    <= hit_cnt_next;
            // x^9 + x^5 + 1 Fibonacci form; all-ones seed keeps it off zero.
            lfsr_reg       <= {lfsr_reg[7:0], lfsr_reg[8] ^ lfsr_reg[4]};
            hit_pulse_reg  <= hit_pulse_next;
            miss_pulse_reg <= miss_pulse_next;
            // Status flags follow the state one clk later.
            game_over_reg  <= (state_reg == ST_OVER);
            is_idle_reg    <= (state_reg != ST_PLAY);
        end
    end

    assign ball_x     = ball_x_reg;
    assign ball_y     = ball_y_reg;
    assign score      = score_reg;
    assign lives      = lives_reg;
    assign speed      = speed_reg;
    assign game_over  = game_over_reg;
    assign is_idle    = is_idle_reg;
    assign hit_pulse  = hit_pulse_reg;
    assign miss_pulse = miss_pulse_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_game_ctrl
//   Directed self-checking bench for pong_game_ctrl with default parameters.
//   Frames are compressed to two clks each; expected values are hand-derived
//   from the game rules, and the ball_x spawn value comes from a local model of
//   the x^9+x^5+1 LFSR running from reset.
// -----------------------------------------------------------------------------
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       start_btn = 1'b0;
    logic       hit_pixel = 1'b0;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [7:0] score;
    logic [2:0] lives;
    logic [3:0] speed;
    logic       game_over;
    logic       is_idle;
    logic       hit_pulse;
    logic       miss_pulse;

    int checks = 0;
    int errors = 0;

    logic [8:0] lfsr_m;
    logic [9:0] exp_x;
    logic       last_hit, last_miss, last_idle;

    pong_game_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .start_btn  (start_btn),
        .hit_pixel  (hit_pixel),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score      (score),
        .lives      (lives),
        .speed      (speed),
        .game_over  (game_over),
        .is_idle    (is_idle),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse)
    );

    always #5 clk = ~clk;

    // Reference LFSR, same polynomial and seed, free-running from reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_m <= 9'h1FF;
        else          lfsr_m <= {lfsr_m[7:0], lfsr_m[8] ^ lfsr_m[4]};
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One compressed frame: frame_start edge, then one quiet clk.
    task automatic frame();
        frame_start = 1'b1;
        tick();
        last_hit    = hit_pulse;
        last_miss   = miss_pulse;
        last_idle   = is_idle;
        frame_start = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    task automatic hits(input int n);
        hit_pixel = 1'b1;
        repeat (n) tick();
        hit_pixel = 1'b0;
    endtask

    task automatic press();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // From SERVE with frame_cnt=0: 29 frames wait, the 30th spawns the ball.
    task automatic serve_to_play();
        frames(29);
        exp_x = {1'b0, lfsr_m};
        frame();
    endtask

    task automatic catch_one();
        hits(16);
        frame();
    endtask

    initial begin
        // ---------------- reset values ----------------
        tick();
        tick();
        check_val("rst_ball_x", ball_x, 310);
        check_val("rst_ball_y", ball_y, 0);
        check_val("rst_score", score, 0);
        check_val("rst_lives", lives, 3);
        check_val("rst_speed", speed, 2);
        check_val("rst_game_over", game_over, 0);
        check_val("rst_is_idle", is_idle, 1);
        check_val("rst_pulses", {hit_pulse, miss_pulse}, 0);
        reset_n = 1'b1;
        tick();

        // ---------------- 1: start and serve ----------------
        press();
        serve_to_play();
        check_val("spawn_ball_x", ball_x, exp_x);
        check_val("spawn_ball_y", ball_y, 0);
        check_val("idle_at_spawn_edge", last_idle, 1);
        check_val("idle_after_spawn", is_idle, 0);

        // ---------------- 2: catches and speed ramp ----------------
        for (int i = 1; i <= 5; i++) begin
            catch_one();
            check_val($sformatf("catch%0d_pulse", i), last_hit, 1);
            check_val($sformatf("catch%0d_score", i), score, i);
            if (i == 4) check_val("speed_after_4", speed, 2);
            if (i < 5) serve_to_play();
        end
        check_val("speed_after_5", speed, 3);
        check_val("idle_in_serve", is_idle, 1);

        // ---------------- 3/4: falling, threshold, misses ----------------
        do_reset();
        press();
        serve_to_play();
        frames(230);
        check_val("ball_y_bottom", ball_y, 460);
        hits(15);
        frame();
        check_val("miss15_miss", last_miss, 1);
        check_val("miss15_hit", last_hit, 0);
        check_val("miss15_lives", lives, 2);
        serve_to_play();
        frames(230);
        hits(16);
        frame();
        check_val("edge_catch_hit", last_hit, 1);
        check_val("edge_catch_miss", last_miss, 0);
        check_val("edge_catch_lives", lives, 2);
        check_val("edge_catch_score", score, 1);
        serve_to_play();
        frames(231);
        check_val("miss2_pulse", last_miss, 1);
        check_val("miss2_lives", lives, 1);
        check_val("miss2_not_over", game_over, 0);
        serve_to_play();
        frames(231);
        check_val("miss3_lives", lives, 0);
        check_val("miss3_game_over", game_over, 1);

        // ---------------- 5a: OVER timeout ----------------
        frames(179);
        check_val("over_179", game_over, 1);
        frame();
        check_val("over_timeout_go", game_over, 0);
        check_val("over_timeout_idle", is_idle, 1);
        check_val("score_retained", score, 1);

        // ---------------- 5b: restart from OVER ----------------
        press();
        check_val("start_clears_score", score, 0);
        serve_to_play();
        catch_one();
        check_val("run2_score", score, 1);
        for (int m = 0; m < 3; m++) begin
            serve_to_play();
            frames(231);
        end
        check_val("run2_over", game_over, 1);
        frames(10);
        press();
        tick();
        check_val("restart_go", game_over, 0);
        check_val("restart_score", score, 0);
        check_val("restart_lives", lives, 3);
        check_val("restart_speed", speed, 2);
        serve_to_play();
        check_val("restart_play", is_idle, 0);

        // ---------------- 6: score saturation and speed ceiling ----------------
        do_reset();
        press();
        for (int i = 1; i <= 100; i++) begin
            serve_to_play();
            catch_one();
            if (i == 99) check_val("score_99", score, 99);
        end
        check_val("sat_score", score, 99);
        check_val("sat_pulse", last_hit, 1);
        check_val("speed_ceiling", speed, 8);

        // ---------------- 6: async reset mid-PLAY ----------------
        do_reset();
        press();
        for (int i = 0; i < 42; i++) begin
            serve_to_play();
            catch_one();
        end
        serve_to_play();
        check_val("pre_rst_score", score, 42);
        check_val("pre_rst_play", is_idle, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_score", score, 0);
        check_val("arst_ball_x", ball_x, 310);
        check_val("arst_ball_y", ball_y, 0);
        check_val("arst_lives", lives, 3);
        check_val("arst_speed", speed, 2);
        check_val("arst_idle", is_idle, 1);
        check_val("arst_flags", {game_over, hit_pulse, miss_pulse}, 0);
        tick();
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
